// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered or first-word-fall-through read, thresholds and sticky error flags
module sync_fifo #(
  parameter int WORD_SIZE     = 8,
  parameter int ADDR_SIZE     = 3,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (1 << ADDR_SIZE) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wen,
  input  logic [WORD_SIZE-1:0] w_word,
  input  logic                 ren,
  input  logic                 err_clr,
  output logic [WORD_SIZE-1:0] r_word,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  // Occupancy constants sized to the count register so every compare is width-matched.
  localparam logic [ADDR_SIZE:0] LP_DEPTH  = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] LP_AFULL  = (ADDR_SIZE + 1)'(AFULL_THRESH);
  localparam logic [ADDR_SIZE:0] LP_AEMPTY = (ADDR_SIZE + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_SIZE:0] LP_ONE    = (ADDR_SIZE + 1)'(1);

  logic [WORD_SIZE-1:0] r_mem [DEPTH];
  logic [ADDR_SIZE:0]   r_wr_ptr;
  logic [ADDR_SIZE:0]   r_rd_ptr;
  logic [ADDR_SIZE:0]   r_count;
  logic                 r_overflow;
  logic                 r_underflow;

  logic [ADDR_SIZE-1:0] w_wr_addr;
  logic [ADDR_SIZE-1:0] w_rd_addr;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic                 w_ovf_evt;
  logic                 w_udf_evt;

  // Status is decoded from the registered count only, never from the request inputs.
  assign w_full    = (r_count == LP_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_wr_addr = r_wr_ptr[ADDR_SIZE-1:0];
  assign w_rd_addr = r_rd_ptr[ADDR_SIZE-1:0];

  // A read needs data; a write needs space, or a simultaneous pop that frees a slot.
  assign w_rd_acc  = ren && !w_empty;
  assign w_wr_acc  = wen && (!w_full || w_rd_acc);
  assign w_ovf_evt = wen && !w_wr_acc;
  assign w_udf_evt = ren && w_empty;

  // Storage array has no reset; stale words are unreachable once count returns to zero.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_addr] <= w_word;
    end
  end

  // Write pointer advances on every accepted write and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (w_wr_acc) begin
      r_wr_ptr <= r_wr_ptr + LP_ONE;
    end
  end

  // Read pointer advances on every accepted read and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (w_rd_acc) begin
      r_rd_ptr <= r_rd_ptr + LP_ONE;
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a fresh error on the clearing edge keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_udf_evt) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [WORD_SIZE-1:0] r_rdata;

      // Registered read port: loads the head word on an accepted read, holds otherwise.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rdata <= '0;
        end else if (w_rd_acc) begin
          r_rdata <= r_mem[w_rd_addr];
        end
      end

      assign r_word = r_rdata;
    end else begin : g_fwft_read
      // Head word is shown combinationally; forced to zero while empty so reset reads as zero.
      assign r_word = w_empty ? '0 : r_mem[w_rd_addr];
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= LP_AFULL);
  assign almost_empty = (r_count <= LP_AEMPTY);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench driving registered-read and FWFT sync_fifo builds in lockstep
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wen = 1'b0;
  logic [7:0] w_word = 8'h00;
  logic       ren = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] r_word0, r_word1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] count0, count1;

  int total = 0;
  int bad = 0;

  logic [7:0] mq[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic       drv_rd_acc = 1'b0;
  logic       fire0 = 1'b0;

  sync_fifo #(.FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .wen(wen), .w_word(w_word), .ren(ren), .err_clr(err_clr),
    .r_word(r_word0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo #(.FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .wen(wen), .w_word(w_word), .ren(ren), .err_clr(err_clr),
    .r_word(r_word1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int n;
    n = mq.size();
    chk({tag, " count0"}, 32'(count0), 32'(n));
    chk({tag, " count1"}, 32'(count1), 32'(n));
    chk({tag, " full0"},  32'(full0),  32'(n == 8));
    chk({tag, " empty0"}, 32'(empty0), 32'(n == 0));
    chk({tag, " afull0"}, 32'(af0),    32'(n >= 7));
    chk({tag, " aempty0"},32'(ae0),    32'(n <= 1));
    chk({tag, " ovf0"},   32'(ovf0),   32'(m_ovf));
    chk({tag, " udf0"},   32'(udf0),   32'(m_udf));
    chk({tag, " empty1"}, 32'(empty1), 32'(n == 0));
    chk({tag, " ovf1"},   32'(ovf1),   32'(m_ovf));
    chk({tag, " udf1"},   32'(udf1),   32'(m_udf));
  endtask

  // One request cycle; entered and left at posedge+1.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic clr, input string tag);
    logic racc, wacc, was_empty;
    was_empty = (mq.size() == 0);
    racc = r && !was_empty;
    wacc = w && ((mq.size() < 8) || racc);
    if (racc) begin
      q0.push_back(mq[0]);
      q1.push_back(mq[0]);
    end
    wen = w; w_word = d; ren = r; err_clr = clr; drv_rd_acc = racc;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; err_clr = 1'b0; drv_rd_acc = 1'b0;
    if (racc) void'(mq.pop_front());
    if (wacc) mq.push_back(d);
    if (w && !wacc)       m_ovf = 1'b1;
    else if (clr)         m_ovf = 1'b0;
    if (r && was_empty)   m_udf = 1'b1;
    else if (clr)         m_udf = 1'b0;
    check_status(tag);
  endtask

  // Registered-read monitor: data is due one cycle after an accepted read.
  always @(posedge clk) fire0 <= drv_rd_acc;

  always @(negedge clk) begin
    if (fire0) begin
      if (q0.size() == 0) chk("sb0 underrun", 32'd1, 32'd0);
      else chk("rd0 data", 32'(r_word0), 32'(q0.pop_front()));
    end
    if (drv_rd_acc) begin
      if (q1.size() == 0) chk("sb1 underrun", 32'd1, 32'd0);
      else chk("rd1 head", 32'(r_word1), 32'(q1.pop_front()));
    end
  end

  initial begin
    #12;
    chk("rst count0", 32'(count0), 32'd0);
    chk("rst empty0", 32'(empty0), 32'd1);
    chk("rst full0",  32'(full0),  32'd0);
    chk("rst ae0",    32'(ae0),    32'd1);
    chk("rst af0",    32'(af0),    32'd0);
    chk("rst ovf0",   32'(ovf0),   32'd0);
    chk("rst udf0",   32'(udf0),   32'd0);
    chk("rst rword0", 32'(r_word0), 32'd0);
    chk("rst rword1", 32'(r_word1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i * 8'h11), 1'b0, 1'b0, "fill");
    step(1'b1, 8'hAA, 1'b0, 1'b0, "ovf");
    step(1'b0, 8'h00, 1'b0, 1'b1, "ovf clr");
    step(1'b1, 8'h99, 1'b1, 1'b0, "full rw");
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");

    step(1'b1, 8'h5A, 1'b1, 1'b0, "empty rw");
    chk("fwft 5A", 32'(r_word1), 32'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0, "pop 5A");
    step(1'b0, 8'h00, 1'b0, 1'b1, "udf clr");

    for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "wrap pre");
    for (int i = 4; i < 24; i++) step(1'b1, 8'(i), 1'b1, 1'b0, "wrap");
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap drain");

    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, "pre rst");
    #2 rst = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    chk("mid rst count0", 32'(count0), 32'd0);
    chk("mid rst empty0", 32'(empty0), 32'd1);
    chk("mid rst count1", 32'(count1), 32'd0);
    chk("mid rst ovf0",   32'(ovf0),   32'd0);
    chk("mid rst udf0",   32'(udf0),   32'd0);
    chk("mid rst rword0", 32'(r_word0), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 8'hC3, 1'b0, 1'b0, "post rst wr");
    step(1'b0, 8'h00, 1'b1, 1'b0, "post rst rd");
    step(1'b0, 8'h00, 1'b0, 1'b0, "idle");
    @(posedge clk);
    #1;
    chk("sb0 drained", 32'(q0.size()), 32'd0);
    chk("sb1 drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL declare parameter WORD_SIZE, default 8, data word width in bits.
REQ-002 The block SHALL declare parameter ADDR_SIZE, default 3, giving storage depth DEPTH = 2^ADDR_SIZE words.
REQ-003 The block SHALL declare parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 The block SHALL declare parameter AFULL_THRESH, default DEPTH-1, almost_full level; legal range 1..DEPTH.
REQ-005 The block SHALL declare parameter AEMPTY_THRESH, default 1, almost_empty level; legal range 0..DEPTH-1.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have port wen, input, 1 bit: write request.
REQ-009 The block SHALL have port w_word, input, WORD_SIZE bits: write data.
REQ-010 The block SHALL have port ren, input, 1 bit: read request (pop in FWFT mode).
REQ-011 The block SHALL have port err_clr, input, 1 bit: synchronous clear of the sticky error flags.
REQ-012 The block SHALL have port r_word, output, WORD_SIZE bits: read data.
REQ-013 The block SHALL have ports full and empty, outputs, 1 bit each: occupancy status.
REQ-014 The block SHALL have ports almost_full and almost_empty, outputs, 1 bit each: threshold status.
REQ-015 The block SHALL have port count, output, ADDR_SIZE+1 bits: current occupancy, 0..DEPTH.
REQ-016 The block SHALL have ports overflow and underflow, outputs, 1 bit each: sticky error flags.

Function
REQ-017 The block SHALL use binary write and read pointers of ADDR_SIZE+1 bits, address storage with the low ADDR_SIZE bits, and wrap modulo 2^(ADDR_SIZE+1).
REQ-018 A read SHALL be accepted iff ren && !empty; the read pointer SHALL advance by 1 on that edge.
REQ-019 A write SHALL be accepted iff wen && (!full || read accepted in the same cycle); the word SHALL be stored at the write pointer and the pointer SHALL advance by 1.
REQ-020 Count SHALL be registered: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-021 Outputs full = (count==DEPTH), empty = (count==0), almost_full = (count>=AFULL_THRESH), almost_empty = (count<=AEMPTY_THRESH), all decoded from registered count only.
REQ-022 In FWFT=0 mode, r_word SHALL be registered, load the word at the read pointer on an accepted-read edge, and hold otherwise; one-cycle read latency.
REQ-023 In FWFT=1 mode, r_word SHALL present the head word whenever empty=0, with no added latency; an accepted read pops it and the next word appears after that edge; r_word is don't-care while empty=1.
REQ-024 In both modes, a word written at edge N SHALL be readable by a read accepted at edge N+1 (empty falls after edge N).
REQ-025 When empty and wen && ren, the write SHALL be accepted, the read rejected, and underflow set.
REQ-026 When full and wen && ren, both SHALL be accepted; count stays DEPTH.
REQ-027 overflow SHALL set on any edge with wen high and the write rejected; underflow SHALL set on any edge with ren high and empty=1.
REQ-028 Both flags SHALL clear on an edge with err_clr=1 unless a new error occurs on that same edge, in which case set wins.
REQ-029 Rejected requests SHALL not alter pointers, count, storage or r_word.

Reset
REQ-030 While rst=1, irrespective of clk: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, r_word=0.
REQ-031 Assertion of rst mid-operation SHALL discard all stored words; storage contents need not be cleared.
REQ-032 After rst deasserts, the first accepted request SHALL be on the next rising clk edge.

Verification
REQ-033 Defaults, FWFT=0: write 0x11..0x88 on 8 edges -> full=1, count=8, almost_full high from count 7; 8 reads -> r_word 0x11..0x88 one cycle after each, empty=1.
REQ-034 Full, wen=1 ren=0 -> overflow=1, count stays 8; err_clr pulse -> overflow=0 next edge.
REQ-035 Full, wen=ren=1 with w_word=0x99 -> count stays 8, 0x11 read out, 0x99 later read as 9th word.
REQ-036 Empty, wen=ren=1, w_word=0x5A -> count=1, underflow=1; FWFT=1 build -> r_word=0x5A right after that edge.
REQ-037 Wrap: 20 write/read pairs of incrementing data at count 3 -> data order preserved, count constant 3.
REQ-038 rst pulse between edges at count 5 -> count=0, empty=1, flags 0 immediately; subsequent write/read returns new data only.
